// File: rtl/gcd_sub_fsm.sv
// Subtraction-method GCD engine driving an external magnitude comparator.
// Optional GCD_ITER_COUNT_EN adds a saturating subtraction counter, iter_cnt.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, a_in, b_in request and operands, accepted in IDLE only
//   cmp_a, cmp_b      operand registers, to the comparator
//   is_equal/great/less comparator flags for cmp_a vs cmp_b
//   busy, done        high in RUN / one-cycle pulse in DONE
//   result            GCD, valid from DONE
//   iter_cnt          subtractions in the last job (GCD_ITER_COUNT_EN)
module gcd_sub_fsm #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             is_equal,
  input  logic             is_great,
  input  logic             is_less,
  output logic             busy,
  output logic             done,
`ifdef GCD_ITER_COUNT_EN
  output logic [WIDTH-1:0] iter_cnt,
`endif
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
`ifdef GCD_ITER_COUNT_EN
  logic [WIDTH-1:0] r_iter;
`endif

  logic             w_zero;
  logic [WIDTH-1:0] w_a_minus_b;
  logic [WIDTH-1:0] w_b_minus_a;

  // Zero check is local so gcd(0,x) never depends on the comparator.
  assign w_zero      = (r_a == '0) || (r_b == '0);
  assign w_a_minus_b = r_a - r_b;
  assign w_b_minus_a = r_b - r_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
      r_iter   <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_state <= S_RUN;
            r_busy  <= 1'b1;
`ifdef GCD_ITER_COUNT_EN
            r_iter  <= '0;
`endif
          end
        end
        S_RUN: begin
          if (w_zero) begin
            r_result <= r_a | r_b;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else if (is_equal) begin
            r_result <= r_a;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else if (is_great) begin
            r_a <= w_a_minus_b;
`ifdef GCD_ITER_COUNT_EN
            if (r_iter != '1)
              r_iter <= r_iter + ONE;
`endif
          end else if (is_less) begin
            r_b <= w_b_minus_a;
`ifdef GCD_ITER_COUNT_EN
            if (r_iter != '1)
              r_iter <= r_iter + ONE;
`endif
          end else begin
            // No flag: a broken comparator must not hang us.
            r_result <= r_a;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign cmp_a  = r_a;
  assign cmp_b  = r_b;
  assign result = r_result;
  assign busy   = r_busy;
  assign done   = r_done;
`ifdef GCD_ITER_COUNT_EN
  assign iter_cnt = r_iter;
`endif

endmodule

// File: tb/tb_gcd_sub_fsm.sv
// Directed bench for gcd_sub_fsm with a behavioural comparator.
// Flag overrides let the bench inject illegal or conflicting flags.
module tb_gcd_sub_fsm;

  localparam int W   = 32;
  localparam int LIM = 300;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] cmp_a;
  logic [W-1:0] cmp_b;
  logic         is_equal;
  logic         is_great;
  logic         is_less;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
`ifdef GCD_ITER_COUNT_EN
  logic [W-1:0] iter_cnt;
`endif

  logic ov_en = 1'b0;
  logic ov_eq = 1'b0;
  logic ov_gt = 1'b0;
  logic ov_lt = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign is_equal = ov_en ? ov_eq : (cmp_a == cmp_b);
  assign is_great = ov_en ? ov_gt : (cmp_a > cmp_b);
  assign is_less  = ov_en ? ov_lt : (cmp_a < cmp_b);

  gcd_sub_fsm #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cmp_a    (cmp_a),
    .cmp_b    (cmp_b),
    .is_equal (is_equal),
    .is_great (is_great),
    .is_less  (is_less),
    .busy     (busy),
    .done     (done),
`ifdef GCD_ITER_COUNT_EN
    .iter_cnt (iter_cnt),
`endif
    .result   (result)
  );

  // Returns the number of negedges after the start edge until done.
  task automatic wait_done(input bit tog, output int n);
    n = 0;
    while (done !== 1'b1 && n <= LIM) begin
      if (tog) begin
        start = n[0];
        a_in  = 32'd99;
        b_in  = 32'd3;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  task automatic run_gcd(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input bit tog,
                         output int n);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(negedge clk);
    start = 1'b0;
    wait_done(tog, n);
  endtask

  task automatic test_reset();
    int k;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00 || result !== '0 ||
        cmp_a !== '0 || cmp_b !== '0) begin
      errors++;
      $display("FAIL reset_init busy=%b done=%b res=%0d a=%0d b=%0d",
               busy, done, result, cmp_a, cmp_b);
    end
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1; a_in = 32'd1; b_in = 32'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prerun busy=%b want 1", busy);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00 || result !== '0 ||
        cmp_a !== '0 || cmp_b !== '0) begin
      errors++;
      $display("FAIL reset_midrun busy=%b done=%b res=%0d a=%0d b=%0d",
               busy, done, result, cmp_a, cmp_b);
    end
    rst = 1'b0;
    k = 0;
    repeat (120) begin
      @(negedge clk);
      if (done === 1'b1) k++;
    end
    checks++;
    if (k != 0) begin
      errors++;
      $display("FAIL reset_nodone pulses=%0d want 0", k);
    end
    rst = 1'b1; start = 1'b1; a_in = 32'd4; b_in = 32'd6;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || cmp_a !== '0) begin
      errors++;
      $display("FAIL reset_vs_start busy=%b a=%0d want 0 0",
               busy, cmp_a);
    end
  endtask

  task automatic test_basic();
    int n;
    run_gcd(32'd12, 32'd18, 1'b0, n);
    checks++;
    if (n != 3 || result !== 32'd6) begin
      errors++;
      $display("FAIL gcd_12_18 n=%0d res=%0d want 3 6", n, result);
    end
`ifdef GCD_ITER_COUNT_EN
    checks++;
    if (iter_cnt !== 32'd2) begin
      errors++;
      $display("FAIL iter_12_18 got %0d want 2", iter_cnt);
    end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd6) begin
      errors++;
      $display("FAIL done_width done=%b busy=%b res=%0d want 0 0 6",
               done, busy, result);
    end
  endtask

  task automatic test_zero();
    int n;
    run_gcd(32'd0, 32'd35, 1'b0, n);
    checks++;
    if (n != 1 || result !== 32'd35) begin
      errors++;
      $display("FAIL gcd_0_35 n=%0d res=%0d want 1 35", n, result);
    end
    run_gcd(32'd0, 32'd0, 1'b0, n);
    checks++;
    if (n != 1 || result !== 32'd0) begin
      errors++;
      $display("FAIL gcd_0_0 n=%0d res=%0d want 1 0", n, result);
    end
    run_gcd(32'd7, 32'd7, 1'b0, n);
    checks++;
    if (n != 1 || result !== 32'd7) begin
      errors++;
      $display("FAIL gcd_7_7 n=%0d res=%0d want 1 7", n, result);
    end
`ifdef GCD_ITER_COUNT_EN
    checks++;
    if (iter_cnt !== 32'd0) begin
      errors++;
      $display("FAIL iter_7_7 got %0d want 0", iter_cnt);
    end
`endif
  endtask

  task automatic test_long_toggle();
    int n;
    run_gcd(32'd1, 32'd20, 1'b1, n);
    checks++;
    if (n != 20 || result !== 32'd1) begin
      errors++;
      $display("FAIL gcd_1_20 n=%0d res=%0d want 20 1", n, result);
    end
`ifdef GCD_ITER_COUNT_EN
    checks++;
    if (iter_cnt !== 32'd19) begin
      errors++;
      $display("FAIL iter_1_20 got %0d want 19", iter_cnt);
    end
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result !== 32'd1) begin
      errors++;
      $display("FAIL toggle_ignored busy=%b res=%0d want 0 1",
               busy, result);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    run_gcd(32'd48, 32'd36, 1'b0, n);
    checks++;
    if (n != 4 || result !== 32'd12) begin
      errors++;
      $display("FAIL gcd_48_36 n=%0d res=%0d want 4 12", n, result);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd12) begin
      errors++;
      $display("FAIL b2b_hold busy=%b done=%b res=%0d want 0 0 12",
               busy, done, result);
    end
    start = 1'b1; a_in = 32'd17; b_in = 32'd5;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept busy=%b want 1", busy);
    end
    wait_done(1'b0, n);
    checks++;
    if (n != 7 || result !== 32'd1) begin
      errors++;
      $display("FAIL gcd_17_5 n=%0d res=%0d want 7 1", n, result);
    end
`ifdef GCD_ITER_COUNT_EN
    checks++;
    if (iter_cnt !== 32'd6) begin
      errors++;
      $display("FAIL iter_17_5 got %0d want 6", iter_cnt);
    end
`endif
  endtask

  task automatic test_flags();
    int n;
    ov_en = 1'b1; ov_eq = 1'b0; ov_gt = 1'b0; ov_lt = 1'b0;
    run_gcd(32'd9, 32'd4, 1'b0, n);
    checks++;
    if (n != 1 || result !== 32'd9) begin
      errors++;
      $display("FAIL no_flags n=%0d res=%0d want 1 9", n, result);
    end
    ov_eq = 1'b1; ov_gt = 1'b1;
    run_gcd(32'd9, 32'd4, 1'b0, n);
    checks++;
    if (n != 1 || result !== 32'd9) begin
      errors++;
      $display("FAIL eq_over_gt n=%0d res=%0d want 1 9", n, result);
    end
    ov_en = 1'b0; ov_eq = 1'b0; ov_gt = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_long_toggle();
    test_back_to_back();
    test_flags();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
